// File: rtl/sc_gametimer_lostdetect.sv
// Game-phase timebase and loss detector: divides CLOCK_50 into game ticks, counts them
// in a wrapping phase counter (reloj) and raises a sticky loss flag on a debounced overlap.
module sc_gametimer_lostdetect #(
    parameter int unsigned TICK_DIV       = 6250000,
    parameter int unsigned RELOJ_LAST     = 155,
    parameter int unsigned COLLIDE_CYCLES = 2
) (
    input  logic       SC_GAMETIMER_CLOCK_50,
    input  logic       SC_GAMETIMER_RESET_InHigh,
    input  logic [1:0] SC_GAMETIMER_shiftselection_transi_In,
    input  logic [1:0] SC_GAMETIMER_shiftselection_random_In,
    input  logic [1:0] SC_GAMETIMER_shiftselection_esencial_In,
    input  logic       SC_GAMETIMER_shiftselection_posicion_In,
    input  logic [7:0] SC_GAMETIMER_playerRow_In,
    input  logic [7:0] SC_GAMETIMER_obstacleRow_In,
    output logic [7:0] SC_GAMETIMER_reloj_Out,
    output logic       SC_GAMETIMER_perdio1_Out,
    output logic       SC_GAMETIMER_tick_Out,
    output logic [1:0] SC_GAMETIMER_state_Out
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    RELOJ_MAX  = 8'(RELOJ_LAST);
    localparam logic [3:0]    COLL_MAX   = 4'(COLLIDE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    reloj_q, reloj_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    coll_q, coll_d;
    logic          perdio_q, perdio_d;
    logic          tick_q, tick_d;

    logic idle_code_s;
    logic lost_code_s;
    logic collide_s;

    // Decode the game FSM's shift-selection outputs and the bottom-line overlap.
    always_comb begin
        idle_code_s = (SC_GAMETIMER_shiftselection_transi_In   == 2'b00) &&
                      (SC_GAMETIMER_shiftselection_random_In   == 2'b00) &&
                      (SC_GAMETIMER_shiftselection_esencial_In == 2'b10) &&
                      (SC_GAMETIMER_shiftselection_posicion_In == 1'b1);
        lost_code_s = (SC_GAMETIMER_shiftselection_esencial_In == 2'b11);
        collide_s   = (SC_GAMETIMER_shiftselection_posicion_In == 1'b0) &&
                      ((SC_GAMETIMER_playerRow_In & SC_GAMETIMER_obstacleRow_In) != 8'h00);
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d  = state_q;
        reloj_d  = reloj_q;
        presc_d  = presc_q;
        coll_d   = coll_q;
        perdio_d = perdio_q;
        tick_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                reloj_d  = 8'd0;
                presc_d  = '0;
                coll_d   = 4'd0;
                perdio_d = 1'b0;
                if (!idle_code_s && !lost_code_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Idle wins over a tick landing on the same edge.
                if (idle_code_s) begin
                    state_d  = ST_IDLE;
                    reloj_d  = 8'd0;
                    presc_d  = '0;
                    coll_d   = 4'd0;
                    perdio_d = 1'b0;
                end else begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (reloj_q >= RELOJ_MAX) begin
                            reloj_d = 8'd0;
                        end else begin
                            reloj_d = reloj_q + 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (collide_s) begin
                        if (coll_q >= COLL_MAX) begin
                            coll_d = COLL_MAX;
                        end else begin
                            coll_d = coll_q + 4'd1;
                        end
                    end else begin
                        coll_d = 4'd0;
                    end
                    if (collide_s && (coll_d == COLL_MAX)) begin
                        perdio_d = 1'b1;
                    end else begin
                        perdio_d = perdio_q;
                    end
                    if (perdio_d || lost_code_s) begin
                        state_d = ST_FROZEN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FROZEN: begin
                if (idle_code_s) begin
                    state_d  = ST_IDLE;
                    reloj_d  = 8'd0;
                    presc_d  = '0;
                    coll_d   = 4'd0;
                    perdio_d = 1'b0;
                end else begin
                    state_d = ST_FROZEN;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                reloj_d  = 8'd0;
                presc_d  = '0;
                coll_d   = 4'd0;
                perdio_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge SC_GAMETIMER_CLOCK_50 or posedge SC_GAMETIMER_RESET_InHigh) begin
        if (SC_GAMETIMER_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            reloj_q  <= 8'd0;
            presc_q  <= '0;
            coll_q   <= 4'd0;
            perdio_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reloj_q  <= reloj_d;
            presc_q  <= presc_d;
            coll_q   <= coll_d;
            perdio_q <= perdio_d;
            tick_q   <= tick_d;
        end
    end

    assign SC_GAMETIMER_reloj_Out   = reloj_q;
    assign SC_GAMETIMER_perdio1_Out = perdio_q;
    assign SC_GAMETIMER_tick_Out    = tick_q;
    assign SC_GAMETIMER_state_Out   = state_q;

endmodule
